cdb_arbiter: RTL and testbench



---
 rtl/cdb_arbiter_if.sv | 29 ++
 rtl/cdb_arbiter.sv | 129 ++++++++++++
 tb/tb_cdb_arbiter.sv | 340 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cdb_arbiter_if.sv
// Result-source to CDB-arbiter bundle: per-source result requests plus the broadcast bus.
// The master modport belongs to the result sources and CDB consumers. The slave modport belongs to the arbiter.
interface cdb_arbiter_if #(
  parameter int NREQ   = 4,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 6
);
  logic [NREQ-1:0]        req_valid;
  logic [NREQ*DATA_W-1:0] req_data;
  logic [NREQ*TAG_W-1:0]  req_tag;
  logic [NREQ-1:0]        req_branch;
  logic [NREQ-1:0]        req_taken;
  logic [NREQ-1:0]        req_ready;
  logic [DATA_W-1:0]      cdb_data;
  logic [TAG_W-1:0]       cdb_tag;
  logic                   cdb_valid;
  logic                   cdb_branch;
  logic                   cdb_branch_taken;

  modport master (
    output req_valid, req_data, req_tag, req_branch, req_taken,
    input  req_ready, cdb_data, cdb_tag, cdb_valid, cdb_branch, cdb_branch_taken
  );

  modport slave (
    input  req_valid, req_data, req_tag, req_branch, req_taken,
    output req_ready, cdb_data, cdb_tag, cdb_valid, cdb_branch, cdb_branch_taken
  );
endinterface

// File: rtl/cdb_arbiter.sv
// CDB arbiter: one holding buffer per result source, round-robin broadcast of one result per cycle.
// Latency: two edges from accept to CDB. With CDB_BYPASS_EN, it is one edge when every holding buffer is empty.
// Backpressure: req_ready[i] is low while buffer i is full and is not being drained this cycle.
module cdb_arbiter #(
  parameter int NREQ   = 4,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 6
) (
  input logic          clk,
  input logic          rst,
  cdb_arbiter_if.slave bus
);
  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef logic [PTR_W-1:0] idx_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [TAG_W-1:0]  tag;
    logic              branch;
    logic              taken;
  } entry_t;

  entry_t          in_entry [NREQ];
  entry_t          hold_q   [NREQ];
  logic [NREQ-1:0] full_q;
  idx_t            ptr_q;
  entry_t          cdb_q;
  logic            cdb_valid_q;

  logic [NREQ-1:0] grant;
  logic            gnt_vld;
  idx_t            gnt_idx;
  logic [NREQ-1:0] accept;
  logic [NREQ-1:0] byp_sel;
  logic            byp_vld;
  idx_t            byp_idx;

  function automatic idx_t wrap_inc(input idx_t i);
    if (int'(i) >= NREQ - 1) return '0;
    return i + idx_t'(1);
  endfunction

  // First set bit of vec in the order start, start+1, ... mod NREQ, returned as {found, index}.
  // Scanning from the far end lets the nearest hit overwrite the result last.
  function automatic logic [PTR_W:0] rr_pick(input logic [NREQ-1:0] vec, input idx_t start);
    logic [PTR_W:0] res;
    int             pos;
    idx_t           p;
    res = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      pos = int'(start) + k;
      if (pos >= NREQ) pos = pos - NREQ;
      p = idx_t'(pos);
      if (vec[p]) res = {1'b1, p};
    end
    return res;
  endfunction

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign in_entry[i].data   = bus.req_data[i*DATA_W +: DATA_W];
    assign in_entry[i].tag    = bus.req_tag[i*TAG_W +: TAG_W];
    assign in_entry[i].branch = bus.req_branch[i];
    assign in_entry[i].taken  = bus.req_taken[i];
  end

  always_comb begin
    {gnt_vld, gnt_idx} = rr_pick(full_q, ptr_q);
    grant = '0;
    if (gnt_vld) grant[gnt_idx] = 1'b1;
  end

  // Ready is a function of buffer state and pointer only, so sources can gate valid on it.
  assign bus.req_ready = ~full_q | grant;
  assign accept        = bus.req_valid & bus.req_ready;

`ifdef CDB_BYPASS_EN
  // With every buffer empty, the nearest requester goes straight onto the CDB.
  always_comb begin
    {byp_vld, byp_idx} = rr_pick(bus.req_valid, ptr_q);
    if (gnt_vld) byp_vld = 1'b0;
    byp_sel = '0;
    if (byp_vld) byp_sel[byp_idx] = 1'b1;
  end
`else
  assign byp_vld = 1'b0;
  assign byp_idx = '0;
  assign byp_sel = '0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full_q      <= '0;
      ptr_q       <= '0;
      cdb_q       <= '0;
      cdb_valid_q <= 1'b0;
    end else begin
      // A refill on the drain edge wins, so the flag stays set.
      for (int i = 0; i < NREQ; i++) begin
        if (accept[i] && !byp_sel[i]) full_q[i] <= 1'b1;
        else if (grant[i])            full_q[i] <= 1'b0;
      end
      if (gnt_vld) begin
        cdb_q       <= hold_q[gnt_idx];
        cdb_valid_q <= 1'b1;
        ptr_q       <= wrap_inc(gnt_idx);
      end else if (byp_vld) begin
        cdb_q       <= in_entry[byp_idx];
        cdb_valid_q <= 1'b1;
        ptr_q       <= wrap_inc(byp_idx);
      end else begin
        cdb_valid_q <= 1'b0;
      end
    end
  end

  // Payload needs no reset: it is only observed through a set full flag.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NREQ; i++) begin
      if (accept[i] && !byp_sel[i]) hold_q[i] <= in_entry[i];
    end
  end

  assign bus.cdb_data         = cdb_q.data;
  assign bus.cdb_tag          = cdb_q.tag;
  assign bus.cdb_branch       = cdb_q.branch;
  assign bus.cdb_branch_taken = cdb_q.taken;
  assign bus.cdb_valid        = cdb_valid_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed scenarios plus a randomized run against a transaction-level model.
module tb_cdb_arbiter;
  localparam int NREQ   = 4;
  localparam int DATA_W = 32;
  localparam int TAG_W  = 6;
`ifdef CDB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam int LAT = BYP ? 0 : 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_total = 0;
  int   n_pass  = 0;

  always #5 clk = ~clk;

  cdb_arbiter_if #(.NREQ(NREQ), .DATA_W(DATA_W), .TAG_W(TAG_W)) bus ();

  cdb_arbiter #(.NREQ(NREQ), .DATA_W(DATA_W), .TAG_W(TAG_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Broadcast log, sampled on the falling edge.
  logic [TAG_W-1:0]  p_tag  [$];
  logic [DATA_W-1:0] p_data [$];
  bit                p_br   [$];
  bit                p_tk   [$];

  always @(negedge clk) begin
    if (bus.cdb_valid === 1'b1) begin
      p_tag.push_back(bus.cdb_tag);
      p_data.push_back(bus.cdb_data);
      p_br.push_back(bus.cdb_branch);
      p_tk.push_back(bus.cdb_branch_taken);
    end
  end

  task automatic p_clear();
    p_tag.delete(); p_data.delete(); p_br.delete(); p_tk.delete();
  endtask

  task automatic clear_inputs();
    bus.req_valid = '0; bus.req_data = '0; bus.req_tag = '0;
    bus.req_branch = '0; bus.req_taken = '0;
  endtask

  task automatic set_src(input int i, input logic [DATA_W-1:0] d, input logic [TAG_W-1:0] t,
                         input bit br, input bit tk);
    bus.req_valid[i] = 1'b1;
    bus.req_data[i*DATA_W +: DATA_W] = d;
    bus.req_tag[i*TAG_W +: TAG_W] = t;
    bus.req_branch[i] = br;
    bus.req_taken[i] = tk;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b0;
    #3;
    @(negedge clk);
    rst = 1'b1;
    p_clear();
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b0;
    #2;
    n_total++; if (bus.cdb_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", bus.cdb_valid); else n_pass++;
    n_total++; if (bus.cdb_data !== '0) $display("FAIL reset_data: got %h want 0", bus.cdb_data); else n_pass++;
    n_total++; if (bus.cdb_tag !== '0) $display("FAIL reset_tag: got %h want 0", bus.cdb_tag); else n_pass++;
    n_total++; if ({bus.cdb_branch, bus.cdb_branch_taken} !== 2'b00)
      $display("FAIL reset_branch: got %b%b want 00", bus.cdb_branch, bus.cdb_branch_taken); else n_pass++;
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_total++; if (bus.req_ready !== 4'hF) $display("FAIL reset_ready: got %b want 1111", bus.req_ready); else n_pass++;
    step();
    n_total++; if (bus.cdb_valid !== 1'b0) $display("FAIL reset_idle_valid: got %b want 0", bus.cdb_valid); else n_pass++;
  endtask

  task automatic test_single();
    do_reset();
    set_src(0, 32'h0000_00AA, 6'd5, 1'b0, 1'b0);
    #1;
    n_total++; if (bus.req_ready[0] !== 1'b1) $display("FAIL single_ready: got %b want 1", bus.req_ready[0]); else n_pass++;
    step();
    clear_inputs();
    n_total++; if (bus.cdb_valid !== BYP) $display("FAIL single_first_edge_valid: got %b want %b", bus.cdb_valid, BYP); else n_pass++;
    repeat (LAT) step();
    n_total++; if (bus.cdb_valid !== 1'b1) $display("FAIL single_valid: got %b want 1", bus.cdb_valid); else n_pass++;
    n_total++; if (bus.cdb_data !== 32'hAA) $display("FAIL single_data: got %h want aa", bus.cdb_data); else n_pass++;
    n_total++; if (bus.cdb_tag !== 6'd5) $display("FAIL single_tag: got %0d want 5", bus.cdb_tag); else n_pass++;
    n_total++; if (bus.cdb_branch !== 1'b0) $display("FAIL single_branch: got %b want 0", bus.cdb_branch); else n_pass++;
    step();
    n_total++; if (bus.cdb_valid !== 1'b0) $display("FAIL single_one_pulse: got %b want 0", bus.cdb_valid); else n_pass++;
  endtask

  task automatic test_all_four();
    do_reset();
    for (int i = 0; i < NREQ; i++) set_src(i, $urandom, TAG_W'(i + 1), 1'b0, 1'b0);
    step();
    clear_inputs();
    repeat (LAT) step();
    for (int k = 0; k < NREQ; k++) begin
      n_total++; if (bus.cdb_valid !== 1'b1 || bus.cdb_tag !== TAG_W'(k + 1))
        $display("FAIL all4_pulse%0d: got valid %b tag %0d want valid 1 tag %0d", k, bus.cdb_valid, bus.cdb_tag, k + 1);
      else n_pass++;
      step();
    end
    n_total++; if (bus.cdb_valid !== 1'b0) $display("FAIL all4_end_valid: got %b want 0", bus.cdb_valid); else n_pass++;
    n_total++; if (bus.req_ready !== 4'hF) $display("FAIL all4_ready: got %b want 1111", bus.req_ready); else n_pass++;
    // The pointer should be back at 0, so source 0 beats source 3.
    set_src(3, $urandom, 6'd9, 1'b0, 1'b0);
    set_src(0, $urandom, 6'd8, 1'b0, 1'b0);
    step();
    clear_inputs();
    repeat (LAT) step();
    n_total++; if (bus.cdb_tag !== 6'd8) $display("FAIL all4_ptr_first: got %0d want 8", bus.cdb_tag); else n_pass++;
    step();
    n_total++; if (bus.cdb_tag !== 6'd9) $display("FAIL all4_ptr_second: got %0d want 9", bus.cdb_tag); else n_pass++;
    step();
  endtask

  task automatic test_stream();
    int next_tag, acc7, idx7, n7, exp_s;
    bit order_ok, rdy7;
    logic [NREQ-1:0] rdy;
    do_reset();
    next_tag = 10; acc7 = 0; rdy7 = 1'b0;
    for (int c = 0; c < 30; c++) begin
      clear_inputs();
      if (next_tag <= 19) set_src(2, $urandom, TAG_W'(next_tag), 1'b0, 1'b0);
      if (c == 3) set_src(1, $urandom, 6'd7, 1'b0, 1'b0);
      #1;
      rdy = bus.req_ready;
      @(posedge clk);
      if (next_tag <= 19 && rdy[2]) next_tag++;
      if (c == 3) begin acc7 = p_tag.size(); rdy7 = rdy[1]; end
      #1;
    end
    clear_inputs();
    idx7 = -1; n7 = 0; exp_s = 10; order_ok = 1'b1;
    foreach (p_tag[k]) begin
      if (p_tag[k] == 6'd7) begin n7++; idx7 = k; end
      else begin if (int'(p_tag[k]) != exp_s) order_ok = 1'b0; exp_s++; end
    end
    n_total++; if (rdy7 !== 1'b1) $display("FAIL stream_accept7: got ready %b want 1", rdy7); else n_pass++;
    n_total++; if (p_tag.size() != 11) $display("FAIL stream_count: got %0d want 11", p_tag.size()); else n_pass++;
    n_total++; if (n7 != 1) $display("FAIL stream_tag7_once: got %0d want 1", n7); else n_pass++;
    n_total++; if (!order_ok || exp_s != 20) $display("FAIL stream_order: got ok=%b last=%0d want ok=1 last=20", order_ok, exp_s); else n_pass++;
    n_total++; if (idx7 < acc7 || idx7 > acc7 + 2)
      $display("FAIL stream_tag7_wait: got pulse index %0d want %0d..%0d", idx7, acc7, acc7 + 2); else n_pass++;
  endtask

  task automatic test_branch();
    logic [DATA_W-1:0] d;
    do_reset();
    d = $urandom;
    set_src(0, $urandom, 6'd2, 1'b0, 1'b0);
    set_src(3, d, 6'h3F, 1'b1, 1'b1);
    step();
    clear_inputs();
    repeat (6) step();
    n_total++; if (p_tag.size() != 2) $display("FAIL branch_count: got %0d want 2", p_tag.size()); else n_pass++;
    n_total++; if (p_br[0] !== 1'b0) $display("FAIL branch_plain: got %b want 0", p_br[0]); else n_pass++;
    n_total++; if (p_tag[1] !== 6'h3F) $display("FAIL branch_tag: got %h want 3f", p_tag[1]); else n_pass++;
    n_total++; if ({p_br[1], p_tk[1]} !== 2'b11) $display("FAIL branch_bits: got %b%b want 11", p_br[1], p_tk[1]); else n_pass++;
    n_total++; if (p_data[1] !== d) $display("FAIL branch_data: got %h want %h", p_data[1], d); else n_pass++;
  endtask

  task automatic test_refill_hold();
    int held;
    bit got;
    logic [TAG_W-1:0] exp_t [5] = '{6'd25, 6'd26, 6'd27, 6'd21, 6'd22};
    do_reset();
    set_src(2, $urandom, 6'd25, 1'b0, 1'b0);
    step();
    clear_inputs();
    set_src(0, $urandom, 6'd27, 1'b0, 1'b0);
    set_src(1, $urandom, 6'd21, 1'b0, 1'b0);
    set_src(3, $urandom, 6'd26, 1'b0, 1'b0);
    step();
    clear_inputs();
    set_src(1, $urandom, 6'd22, 1'b0, 1'b0);
    held = 0; got = 1'b0;
    while (!got && held < 8) begin
      #1;
      if (bus.req_ready[1] === 1'b1) got = 1'b1;
      else begin held++; step(); end
    end
    n_total++; if (!got) $display("FAIL refill_timeout: got no ready within 8 cycles want ready"); else n_pass++;
    step();
    clear_inputs();
    n_total++; if (held != (BYP ? 1 : 2)) $display("FAIL refill_held: got %0d want %0d", held, BYP ? 1 : 2); else n_pass++;
    repeat (6) step();
    n_total++; if (p_tag.size() != 5) $display("FAIL refill_count: got %0d want 5", p_tag.size()); else n_pass++;
    for (int k = 0; k < 5 && k < p_tag.size(); k++) begin
      n_total++; if (p_tag[k] !== exp_t[k]) $display("FAIL refill_seq%0d: got %0d want %0d", k, p_tag[k], exp_t[k]); else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < NREQ; i++) set_src(i, $urandom, TAG_W'(30 + i), 1'b0, 1'b0);
    step();
    clear_inputs();
    repeat (LAT) step();
    n_total++; if (bus.cdb_valid !== 1'b1 || bus.cdb_tag !== 6'd30)
      $display("FAIL rstmid_pre: got valid %b tag %0d want 1 30", bus.cdb_valid, bus.cdb_tag); else n_pass++;
    #2;
    rst = 1'b0;
    #1;
    n_total++; if (bus.cdb_valid !== 1'b0) $display("FAIL rstmid_valid: got %b want 0", bus.cdb_valid); else n_pass++;
    n_total++; if (bus.cdb_tag !== '0 || bus.cdb_data !== '0)
      $display("FAIL rstmid_bus: got tag %h data %h want 0 0", bus.cdb_tag, bus.cdb_data); else n_pass++;
    n_total++; if (bus.req_ready !== 4'hF) $display("FAIL rstmid_ready: got %b want 1111", bus.req_ready); else n_pass++;
    @(negedge clk);
    rst = 1'b1;
    p_clear();
    repeat (8) step();
    n_total++; if (p_tag.size() != 0) $display("FAIL rstmid_stale: got %0d pulses want 0", p_tag.size()); else n_pass++;
  endtask

  task automatic test_random();
    bit                m_full [NREQ];
    logic [DATA_W-1:0] m_data [NREQ];
    logic [TAG_W-1:0]  m_tag  [NREQ];
    bit                m_br   [NREQ];
    bit                m_tk   [NREQ];
    bit                s_vld  [NREQ];
    logic [DATA_W-1:0] s_data [NREQ];
    logic [TAG_W-1:0]  s_tag  [NREQ];
    bit                s_br   [NREQ];
    bit                s_tk   [NREQ];
    logic [DATA_W-1:0] e_data;
    logic [TAG_W-1:0]  e_tag;
    bit                e_vld, e_br, e_tk;
    logic [NREQ-1:0]   e_rdy;
    int m_ptr, g, b, rate, acc_cnt, dut_bc, errs;
    do_reset();
    for (int i = 0; i < NREQ; i++) begin m_full[i] = 1'b0; s_vld[i] = 1'b0; end
    m_ptr = 0; e_data = '0; e_tag = '0; e_vld = 1'b0; e_br = 1'b0; e_tk = 1'b0;
    acc_cnt = 0; dut_bc = 0; errs = 0; rate = 2;
    for (int c = 0; c < 600; c++) begin
      if (c % 100 == 0) rate = $urandom_range(1, 4);
      if (c >= 580) rate = 0;
      for (int i = 0; i < NREQ; i++) begin
        if (!s_vld[i] && $urandom_range(0, 3) < rate) begin
          s_vld[i] = 1'b1; s_data[i] = $urandom; s_tag[i] = TAG_W'($urandom);
          s_br[i] = 1'($urandom); s_tk[i] = 1'($urandom);
        end
        bus.req_valid[i] = s_vld[i];
        bus.req_data[i*DATA_W +: DATA_W] = s_data[i];
        bus.req_tag[i*TAG_W +: TAG_W] = s_tag[i];
        bus.req_branch[i] = s_br[i];
        bus.req_taken[i] = s_tk[i];
      end
      g = -1;
      for (int k = 0; k < NREQ; k++) begin
        int j = (m_ptr + k) % NREQ;
        if (g < 0 && m_full[j]) g = j;
      end
      for (int i = 0; i < NREQ; i++) e_rdy[i] = !m_full[i] || (i == g);
      #1;
      n_total++; if (bus.req_ready !== e_rdy) begin errs++; $display("FAIL rand_ready c%0d: got %b want %b", c, bus.req_ready, e_rdy); end else n_pass++;
      @(posedge clk);
      b = -1;
`ifdef CDB_BYPASS_EN
      if (g < 0) begin
        for (int k = 0; k < NREQ; k++) begin
          int j = (m_ptr + k) % NREQ;
          if (b < 0 && s_vld[j]) b = j;
        end
      end
`endif
      if (g >= 0) begin
        e_vld = 1'b1; e_data = m_data[g]; e_tag = m_tag[g]; e_br = m_br[g]; e_tk = m_tk[g];
        m_full[g] = 1'b0; m_ptr = (g + 1) % NREQ;
      end else if (b >= 0) begin
        e_vld = 1'b1; e_data = s_data[b]; e_tag = s_tag[b]; e_br = s_br[b]; e_tk = s_tk[b];
        m_ptr = (b + 1) % NREQ;
      end else begin
        e_vld = 1'b0;
      end
      for (int i = 0; i < NREQ; i++) begin
        if (s_vld[i] && e_rdy[i]) begin
          if (i != b) begin
            m_full[i] = 1'b1; m_data[i] = s_data[i]; m_tag[i] = s_tag[i]; m_br[i] = s_br[i]; m_tk[i] = s_tk[i];
          end
          s_vld[i] = 1'b0;
          acc_cnt++;
        end
      end
      #1;
      if (bus.cdb_valid === 1'b1) dut_bc++;
      n_total++; if (bus.cdb_valid !== e_vld) begin errs++; $display("FAIL rand_valid c%0d: got %b want %b", c, bus.cdb_valid, e_vld); end else n_pass++;
      n_total++; if (bus.cdb_tag !== e_tag) begin errs++; $display("FAIL rand_tag c%0d: got %h want %h", c, bus.cdb_tag, e_tag); end else n_pass++;
      n_total++; if (bus.cdb_data !== e_data) begin errs++; $display("FAIL rand_data c%0d: got %h want %h", c, bus.cdb_data, e_data); end else n_pass++;
      n_total++; if ({bus.cdb_branch, bus.cdb_branch_taken} !== {e_br, e_tk})
        begin errs++; $display("FAIL rand_branch c%0d: got %b%b want %b%b", c, bus.cdb_branch, bus.cdb_branch_taken, e_br, e_tk); end
      else n_pass++;
      if (errs > 20) begin
        $display("FAIL rand_abort: got %0d errors want 0", errs);
        break;
      end
    end
    clear_inputs();
    n_total++; if (dut_bc != acc_cnt) $display("FAIL rand_conservation: got %0d broadcasts want %0d", dut_bc, acc_cnt); else n_pass++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_all_four();
    test_stream();
    test_branch();
    test_refill_hold();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
